// File: rtl/hid_hub_pkg.sv
// Shared helpers for the HID report hub: ceiling log2, report width and
// channel-index width. Used for parameter-derived widths only.
package hid_hub_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Bits per channel report.
    function automatic int report_width(input int report_bytes);
        return 8 * report_bytes;
    endfunction

    // Width of a channel index; never narrower than one bit.
    function automatic int idx_width(input int channels);
        return (channels > 1) ? clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/hid_hub_fifo.sv
// Synchronous first-word-fall-through FIFO for channel-index events.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write request and data
//   pop             read request (ignored when empty)
//   pop_data        head entry, zero when empty
//   empty, full     occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module hid_hub_fifo
    import hid_hub_pkg::*;
#(
    parameter int C_width = 1,
    parameter int C_depth = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [C_width-1:0] push_data,
    input  logic               pop,
    output logic [C_width-1:0] pop_data,
    output logic               empty,
    output logic               full
);

    localparam int AW = clog2(C_depth);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(C_depth);

    logic [C_width-1:0] mem [C_depth];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               do_push;
    logic               do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_MAX);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; pop_data is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/hid_report_hub.sv
// Multi-channel HID report collector. Latches the newest report of each
// channel into a packed display vector, raises an event when a report
// changes (or on every report), serialises events through a round-robin
// arbiter into a small FIFO, and marks channels whose host went silent.
// Ports:
//   clk, rst          USB clock, asynchronous active-high reset
//   hid_valid         per-channel one-cycle report strobe
//   hid_report        channel i at [i*W +: W]
//   display           latched reports, channel 0 in the LSBs
//   stale             1 = channel has no live report
//   ev_valid/ev_ready event handshake: the head entry on ev_channel is
//                     consumed on a cycle where ev_valid & ev_ready are both
//                     high; ev_channel holds steady while ev_valid & ~ev_ready
//   ev_overflow       sticky: an event was coalesced into a pending one
//   ev_overflow_clr   clears ev_overflow (a same-cycle set wins)
module hid_report_hub
    import hid_hub_pkg::*;
#(
    parameter int C_channels     = 2,
    parameter int C_report_bytes = 8,
    parameter int C_fifo_depth   = 4,
    parameter int C_all_events   = 0,
    parameter int C_stale_cycles = 0,
    parameter int C_stale_blank  = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [C_channels-1:0]                         hid_valid,
    input  logic [C_channels*report_width(C_report_bytes)-1:0] hid_report,
    output logic [C_channels*report_width(C_report_bytes)-1:0] display,
    output logic [C_channels-1:0]                         stale,
    output logic                                          ev_valid,
    input  logic                                          ev_ready,
    output logic [idx_width(C_channels)-1:0]              ev_channel,
    output logic                                          ev_overflow,
    input  logic                                          ev_overflow_clr
);

    localparam int W   = report_width(C_report_bytes);
    localparam int IW  = idx_width(C_channels);
    localparam int WDW = (C_stale_cycles > 0) ? clog2(C_stale_cycles + 1) : 1;
    localparam logic [WDW-1:0] WD_MAX  = WDW'(C_stale_cycles);
    localparam logic [WDW-1:0] WD_LAST = WDW'((C_stale_cycles > 0) ? C_stale_cycles - 1 : 0);
    localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

    logic [W-1:0]          disp_q [C_channels];
    logic [WDW-1:0]        wd_q   [C_channels];
    logic [C_channels-1:0] stale_q;
    logic [C_channels-1:0] pending_q;
    logic [IW-1:0]         rr_q;
    logic                  ovf_q;

    logic [C_channels-1:0] ev_raise;
    logic [C_channels-1:0] grant_vec;
    logic [IW-1:0]         grant_idx;
    logic                  grant_valid;
    logic                  can_push;
    logic                  ovf_set;
    logic                  fifo_empty;
    logic                  fifo_full;

    always_comb begin
        display = '0;
        for (int i = 0; i < C_channels; i++) begin
            display[i*W +: W] = disp_q[i];
        end
    end

    assign stale       = stale_q;
    assign ev_overflow = ovf_q;
    assign ev_valid    = ~fifo_empty;

    // Change detection compares against the registered slice, so a stale
    // (possibly blanked) channel always raises an event on its next report.
    always_comb begin
        ev_raise = '0;
        for (int i = 0; i < C_channels; i++) begin
            ev_raise[i] = hid_valid[i] &
                          ((C_all_events != 0) || (hid_report[i*W +: W] != disp_q[i]) || stale_q[i]);
        end
    end

    // A full FIFO still accepts a grant when the consumer pops this cycle.
    assign can_push = ~fifo_full | ev_ready;

    // Round-robin: first pending channel at or above rr_q, wrapping.
    always_comb begin
        int j;
        j           = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        if (can_push) begin
            for (int k = 0; k < C_channels; k++) begin
                j = (int'(rr_q) + k) % C_channels;
                if (!grant_valid && pending_q[j]) begin
                    grant_valid  = 1'b1;
                    grant_idx    = IW'(j);
                    grant_vec[j] = 1'b1;
                end
            end
        end
    end

    // Coalescing only counts when the pending bit is not being drained now.
    assign ovf_set = |(ev_raise & pending_q & ~grant_vec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            rr_q      <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~grant_vec) | ev_raise;
            if (grant_valid) rr_q <= IW'((int'(grant_idx) + 1) % C_channels);
            if (ovf_set)              ovf_q <= 1'b1;
            else if (ev_overflow_clr) ovf_q <= 1'b0;
        end
    end

    // Capture and stale watchdog; a report in the expiry cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stale_q <= '1;
            for (int i = 0; i < C_channels; i++) begin
                disp_q[i] <= '0;
                wd_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < C_channels; i++) begin
                if (hid_valid[i]) begin
                    disp_q[i]  <= hid_report[i*W +: W];
                    stale_q[i] <= 1'b0;
                    wd_q[i]    <= '0;
                end else if ((C_stale_cycles > 0) && (wd_q[i] != WD_MAX)) begin
                    wd_q[i] <= wd_q[i] + WD_ONE;
                    if (wd_q[i] == WD_LAST) begin
                        stale_q[i] <= 1'b1;
                        if (C_stale_blank != 0) disp_q[i] <= '0;
                    end
                end
            end
        end
    end

    hid_hub_fifo #(
        .C_width (IW),
        .C_depth (C_fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_valid),
        .push_data (grant_idx),
        .pop       (ev_ready),
        .pop_data  (ev_channel),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_hid_report_hub.sv
module tb_hid_report_hub;

    localparam int NCH   = 2;
    localparam int W     = 64;
    localparam int DEPTH = 4;
    localparam int STALE = 100;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NCH-1:0]     hid_valid = '0;
    logic [NCH*W-1:0]   hid_report = '0;
    logic [NCH*W-1:0]   display;
    logic [NCH-1:0]     stale;
    logic               ev_valid;
    logic               ev_ready = 1'b0;
    logic [0:0]         ev_channel;
    logic               ev_overflow;
    logic               ev_overflow_clr = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    hid_report_hub #(
        .C_channels     (NCH),
        .C_report_bytes (8),
        .C_fifo_depth   (DEPTH),
        .C_all_events   (0),
        .C_stale_cycles (STALE),
        .C_stale_blank  (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hid_valid       (hid_valid),
        .hid_report      (hid_report),
        .display         (display),
        .stale           (stale),
        .ev_valid        (ev_valid),
        .ev_ready        (ev_ready),
        .ev_channel      (ev_channel),
        .ev_overflow     (ev_overflow),
        .ev_overflow_clr (ev_overflow_clr)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Behavioural view: each channel keeps its last report and the number of
    // cycles since it last reported; change events wait in a per-channel
    // pending flag and are moved into a queue in round-robin order.
    logic [W-1:0] m_disp [NCH];
    bit           m_stale [NCH];
    int           m_age   [NCH];
    bit           m_pend  [NCH];
    int           m_rr;
    bit           m_ovf;
    int           m_q[$];
    logic [0:0]   exp_q[$];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_disp[c] = '0; m_stale[c] = 1; m_age[c] = 0; m_pend[c] = 0;
        end
        m_rr = 0; m_ovf = 0;
        m_q.delete();
        exp_q.delete();
    endtask

    task automatic model_step();
        bit pop;
        bit space;
        int grant;
        bit raise [NCH];
        bit ovf_hit;
        logic [W-1:0] rep;
        pop   = ev_ready && (m_q.size() > 0);
        space = (m_q.size() < DEPTH) || pop;
        for (int c = 0; c < NCH; c++) begin
            rep = hid_report[c*W +: W];
            raise[c] = hid_valid[c] && ((rep != m_disp[c]) || m_stale[c]);
        end
        grant = -1;
        if (space) begin
            for (int k = 0; k < NCH; k++) begin
                if (grant < 0 && m_pend[(m_rr + k) % NCH]) grant = (m_rr + k) % NCH;
            end
        end
        ovf_hit = 0;
        for (int c = 0; c < NCH; c++) begin
            if (raise[c] && m_pend[c] && c != grant) ovf_hit = 1;
            if (c == grant) m_pend[c] = 0;
            if (raise[c]) m_pend[c] = 1;
        end
        if (ovf_hit) m_ovf = 1;
        else if (ev_overflow_clr) m_ovf = 0;
        if (pop) void'(m_q.pop_front());
        if (grant >= 0) begin
            m_q.push_back(grant);
            exp_q.push_back(1'(grant));
            m_rr = (grant + 1) % NCH;
        end
        for (int c = 0; c < NCH; c++) begin
            if (hid_valid[c]) begin
                m_disp[c] = hid_report[c*W +: W]; m_stale[c] = 0; m_age[c] = 0;
            end else if (m_age[c] < STALE) begin
                m_age[c]++;
                if (m_age[c] == STALE) begin
                    m_stale[c] = 1; m_disp[c] = '0;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_display", display, '0);
                chk("rst_stale", stale, 2'b11);
                chk("rst_ev_valid", ev_valid, 1'b0);
                chk("rst_ev_overflow", ev_overflow, 1'b0);
            end else begin
                chk("display", display, {m_disp[1], m_disp[0]});
                chk("stale", stale, {m_stale[1], m_stale[0]});
                chk("ev_overflow", ev_overflow, m_ovf);
                chk("ev_valid", ev_valid, m_q.size() != 0);
                if (ev_valid && ev_ready) begin
                    if (exp_q.size() == 0) chk("ev_unexpected", 1'b1, 1'b0);
                    else chk("ev_channel", ev_channel, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic [1:0] v, input logic [63:0] r0, input logic [63:0] r1,
                        input logic rdy, input logic clr);
        hid_valid       = v;
        hid_report      = {r1, r0};
        ev_ready        = rdy;
        ev_overflow_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(2'b00, 64'h0, 64'h0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hid_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [63:0] pick_report();
        logic [63:0] r;
        case ($urandom_range(0, 3))
            0:       r = 64'h0;
            1:       r = 64'h0000_0000_0004_0000;
            2:       r = 64'h0000_0000_0005_0002;
            default: r = {$urandom, $urandom};
        endcase
        return r;
    endfunction

    initial begin
        logic [63:0] ra;
        int budget;
        // Reset check window.
        @(posedge clk); #1;
        do_reset();

        // Single event and its latency; then an identical resend.
        step(2'b01, 64'h0000_0000_0004_0000, 64'h0, 1'b0, 1'b0);
        chk("lat_display_t1", display[63:0], 64'h0000_0000_0004_0000);
        chk("lat_ev_valid_t1", ev_valid, 1'b0);
        step(2'b00, 64'h0, 64'h0, 1'b0, 1'b0);
        chk("lat_ev_valid_t2", ev_valid, 1'b1);
        chk("lat_ev_channel_t2", ev_channel, 1'b0);
        idle(3, 1'b1);
        step(2'b01, 64'h0000_0000_0004_0000, 64'h0, 1'b1, 1'b0);
        idle(3, 1'b1);
        chk("same_report_no_event", ev_valid, 1'b0);

        // Simultaneous changes on both channels, twice.
        step(2'b11, 64'h11, 64'h22, 1'b1, 1'b0);
        idle(5, 1'b1);
        step(2'b11, 64'h33, 64'h44, 1'b1, 1'b0);
        step(2'b11, 64'h55, 64'h66, 1'b1, 1'b0);
        idle(6, 1'b1);

        // Fill FIFO with ready low, hold pending, coalesce, clear-vs-set.
        do_reset();
        step(2'b01, 64'hA0, 64'h0, 1'b0, 1'b0);
        step(2'b10, 64'h0, 64'hB0, 1'b0, 1'b0);
        step(2'b01, 64'hA1, 64'h0, 1'b0, 1'b0);
        step(2'b10, 64'h0, 64'hB1, 1'b0, 1'b0);
        step(2'b01, 64'hA2, 64'h0, 1'b0, 1'b0);
        step(2'b10, 64'h0, 64'hB2, 1'b0, 1'b0);
        chk("full_no_overflow_yet", ev_overflow, 1'b0);
        step(2'b01, 64'hA3, 64'h0, 1'b0, 1'b0);
        chk("coalesce_overflow", ev_overflow, 1'b1);
        step(2'b10, 64'h0, 64'hB3, 1'b0, 1'b1);
        chk("set_beats_clr", ev_overflow, 1'b1);
        step(2'b00, 64'h0, 64'h0, 1'b0, 1'b1);
        chk("clr_overflow", ev_overflow, 1'b0);
        // Pop and push in the same cycle while full.
        step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(10, 1'b1);

        // Watchdog on channel 1 while channel 0 stays active.
        step(2'b10, 64'h0, 64'hC0FFEE, 1'b1, 1'b0);
        for (int i = 0; i < STALE - 1; i++)
            step({1'b0, (i % 10) == 0}, 64'h0000_0000_0004_0000 + 64'(i % 20 == 0), 64'h0, 1'b1, 1'b0);
        chk("wd_not_yet_stale", stale[1], 1'b0);
        step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
        chk("wd_stale", stale[1], 1'b1);
        chk("wd_blank", display[127:64], 64'h0);
        idle(3, 1'b1);
        step(2'b10, 64'h0, 64'h0, 1'b1, 1'b0);
        chk("wd_revive", stale[1], 1'b0);
        step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
        chk("wd_revive_event", ev_valid, 1'b1);
        idle(4, 1'b1);

        // Randomised traffic with a mid-stream reset.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            ra = pick_report();
            step(2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3)), ra, pick_report(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        // Sparse traffic so channels go stale.
        for (int i = 0; i < 600; i++) begin
            step({$urandom_range(0, 79) == 0, $urandom_range(0, 79) == 0},
                 pick_report(), pick_report(), $urandom_range(0, 1) == 1, 1'b0);
        end

        // Drain with a bounded budget.
        budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
            budget--;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_ev_valid", ev_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
